product_accumulator: RTL and testbench

- Downstream consumer of the 8x8 Wallace multiplier. It accepts the 16-bit product stream through a valid/ready handshake and sums a programmable-length block of products into a saturating accumulator.
- Each block result is presented on a valid/ready output port.
- It turns the combinational multiplier into a dot-product/MAC datapath stage.

---
 rtl/product_accumulator_pkg.sv | 8 +
 rtl/product_accumulator_sat.sv | 16 +
 rtl/product_accumulator.sv | 81 ++++++++
 tb/tb_product_accumulator.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: shared widths, saturation constant and state encoding
package product_accumulator_pkg;
    localparam int PROD_W_D = 16;
    localparam int ACC_W_D  = 20;
    localparam int CNT_W_D  = 4;
    localparam logic [ACC_W_D-1:0] ACC_MAX_D = '1;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/product_accumulator_sat.sv
// sat_adder: unsigned accumulator + product adder that clamps to all-ones on carry-out
module sat_adder #(
    parameter int ACC_W  = 20,
    parameter int PROD_W = 16
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);
    localparam logic [ACC_W-1:0] SAT = '1;
    logic [ACC_W:0] full;
    assign full = {1'b0, a} + (ACC_W+1)'(b);
    assign ovf  = full[ACC_W];
    assign sum  = ovf ? SAT : full[ACC_W-1:0];
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmable-length block of products into a saturating accumulator
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_D,
    parameter int ACC_W  = ACC_W_D,
    parameter int CNT_W  = CNT_W_D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic [CNT_W-1:0]  len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow
);
    state_t state, state_nx;
    logic [ACC_W-1:0] acc, add_sum;
    logic add_ovf, ovf, beat, take;
    logic [CNT_W:0] count, len_q, len_eff;

    assign in_ready     = state != HOLD;
    assign out_valid    = state == HOLD;
    assign out_sum      = acc;
    assign out_overflow = ovf;
    assign beat         = in_valid && in_ready;
    assign take         = out_valid && out_ready;
    assign len_eff      = (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};

    sat_adder #(.ACC_W(ACC_W), .PROD_W(PROD_W)) u_add (
        .a(acc), .b(in_product), .sum(add_sum), .ovf(add_ovf)
    );

    // next state: clear wins over any beat or result transfer
    always_comb begin
        state_nx = state;
        if (clear)
            state_nx = IDLE;
        else if (state == IDLE && beat)
            state_nx = (len_eff == (CNT_W+1)'(1)) ? HOLD : ACCUM;
        else if (state == ACCUM && beat && count + 1'b1 == len_q)
            state_nx = HOLD;
        else if (state == HOLD && take)
            state_nx = IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // datapath: first beat loads, later beats add with sticky saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (state == IDLE && beat) begin
            acc   <= ACC_W'(in_product);
            count <= (CNT_W+1)'(1);
            ovf   <= 1'b0;
            len_q <= len_eff;
        end else if (state == ACCUM && beat) begin
            acc   <= add_sum;
            ovf   <= ovf | add_ovf;
            count <= count + 1'b1;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed table-driven checks of block sums, saturation, backpressure, clear and reset
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [15:0] in_product = '0;
    logic [3:0] len = '0;
    logic in_ready, out_valid, out_overflow;
    logic [19:0] out_sum;
    logic s_in_ready, s_out_valid, s_out_overflow;
    logic [16:0] s_out_sum;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    product_accumulator u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .len(len), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_overflow(out_overflow)
    );

    product_accumulator #(.ACC_W(17)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_product(in_product), .len(len), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sum(s_out_sum), .out_overflow(s_out_overflow)
    );

    typedef struct {
        logic [3:0]  len;
        int          n;
        int          gap;
        logic [15:0] p [4];
        logic [19:0] sum;
        logic        ovf;
        logic        sel;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic [3:0] l, input int n, input int gap,
                                input logic [15:0] p0, input logic [15:0] p1,
                                input logic [15:0] p2, input logic [15:0] p3,
                                input logic [19:0] sum, input logic ovf, input logic sel);
        vec_t v;
        v.len = l; v.n = n; v.gap = gap;
        v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
        v.sum = sum; v.ovf = ovf; v.sel = sel;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic beat(input logic [15:0] p, input logic [3:0] l);
        chk("in_ready_before_beat", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_product = p;
        len = l;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic result(input string nm, input logic [19:0] sum, input logic ovf, input logic sel);
        chk({nm, "_valid"}, 32'(sel ? s_out_valid : out_valid), 32'd1);
        chk({nm, "_sum"}, sel ? 32'(s_out_sum) : 32'(out_sum), 32'(sum));
        chk({nm, "_ovf"}, 32'(sel ? s_out_overflow : out_overflow), 32'(ovf));
        chk({nm, "_hold_ready"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = mk(4'd1, 1, 0, 16'd15, 16'd0, 16'd0, 16'd0, 20'd15, 1'b0, 1'b0);
        vecs[1] = mk(4'd4, 4, 2, 16'd4004, 16'd38130, 16'd64770, 16'd15, 20'd106919, 1'b0, 1'b0);
        vecs[2] = mk(4'd3, 3, 0, 16'd65535, 16'd65535, 16'd65535, 16'd0, 20'd196605, 1'b0, 1'b0);
        vecs[3] = mk(4'd3, 3, 0, 16'd65026, 16'd65026, 16'd65026, 16'd0, 20'h1FFFF, 1'b1, 1'b1);
        vecs[4] = mk(4'd4, 4, 1, 16'd65535, 16'd65535, 16'd65535, 16'd1, 20'h1FFFF, 1'b1, 1'b1);
        vecs[5] = mk(4'd1, 1, 0, 16'd7, 16'd0, 16'd0, 16'd0, 20'd7, 1'b0, 1'b1);
        vecs[6] = mk(4'd2, 2, 0, 16'd0, 16'd0, 16'd0, 16'd0, 20'd0, 1'b0, 1'b0);

        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_ovf", 32'(out_overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                beat(vecs[v].p[i], vecs[v].len);
                if (i < vecs[v].n - 1) begin
                    repeat (vecs[v].gap) @(negedge clk);
                    chk("mid_block_valid", 32'(out_valid), 32'd0);
                end
            end
            result($sformatf("vec%0d", v), vecs[v].sum, vecs[v].ovf, vecs[v].sel);
        end

        for (int i = 0; i < 15; i++) beat(16'd64770, 4'd0);
        chk("full_15_valid", 32'(out_valid), 32'd0);
        beat(16'd64770, 4'd0);
        result("full16", 20'hFD020, 1'b0, 1'b0);

        beat(16'd100, 4'd2);
        beat(16'd200, 4'd9);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_product = 16'd999;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(out_sum), 32'd300);
            chk("bp_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        result("bp", 20'd300, 1'b0, 1'b0);
        beat(16'd5, 4'd1);
        result("after_bp", 20'd5, 1'b0, 1'b0);

        beat(16'd10, 4'd4);
        beat(16'd20, 4'd4);
        clear = 1'b1;
        in_valid = 1'b1;
        in_product = 16'd30;
        chk("clear_cycle_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear_valid", 32'(out_valid), 32'd0);
        chk("clear_sum", 32'(out_sum), 32'd0);
        chk("clear_ready", 32'(in_ready), 32'd1);
        beat(16'd9, 4'd1);
        result("after_clear", 20'd9, 1'b0, 1'b0);

        beat(16'd42, 4'd1);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sum", 32'(out_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        beat(16'd3, 4'd1);
        result("post_rst", 20'd3, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
